// File: rtl/fios_mm_sequencer.sv
// ---------------------------------------------------------------------------
// fios_mm_sequencer
//
// Purpose:
//   Sequences one Montgomery FIOS multiplication across an expanded chain of
//   PE_NB processing elements, one PE per operand word. Every timing output
//   is decoded from a single run counter. This reproduces the chain's
//   PE_DELAY skew between neighbouring PEs exactly.
//
// Ports:
//   clock_i      in   rising-edge clock
//   reset_i      in   synchronous active-high reset; abandons an in-flight run
//   start_i      in   multiplication request, accepted only while ready_o=1
//   ready_o      out  sequencer idle, can accept start_i
//   op_valid_o   out  a b/p operand word is presented this cycle
//   word_idx_o   out  index of the operand word to present
//   a_reg_en_o   out  per-PE a-word load pulse
//   m_reg_en_o   out  per-PE m-register load pulse
//   pe_active_o  out  per-PE processing window (mux/OPMODE steering)
//   res_valid_o  out  RES of the last PE holds a result word this cycle
//   res_idx_o    out  index of the current result word
//   done_o       out  one-cycle pulse after the final result word
// ---------------------------------------------------------------------------
module fios_mm_sequencer #(
  parameter int s           = 8,
  parameter int PE_NB       = 8,
  parameter int PE_DELAY    = 10,
  parameter int M_OFFSET    = 4,
  parameter int RES_LATENCY = 90
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic                 ready_o,
  output logic                 op_valid_o,
  output logic [$clog2(s)-1:0] word_idx_o,
  output logic [PE_NB-1:0]     a_reg_en_o,
  output logic [PE_NB-1:0]     m_reg_en_o,
  output logic [PE_NB-1:0]     pe_active_o,
  output logic                 res_valid_o,
  output logic [$clog2(s)-1:0] res_idx_o,
  output logic                 done_o
);

  localparam int T_END = RES_LATENCY + s;
  localparam int CW    = $clog2(T_END + 1);
  localparam int IW    = $clog2(s);

  // Parameter sanity checks. The result must not appear before the last PE
  // has loaded its m-register, otherwise the decoded windows are meaningless.
  if (PE_NB != s) begin : g_chk_pe_nb
    $error("fios_mm_sequencer: PE_NB (%0d) must equal s (%0d)", PE_NB, s);
  end
  if (M_OFFSET < 1 || M_OFFSET > PE_DELAY - 1) begin : g_chk_m_offset
    $error("fios_mm_sequencer: M_OFFSET (%0d) must be in 1..PE_DELAY-1", M_OFFSET);
  end
  if (RES_LATENCY < (PE_NB - 1) * PE_DELAY + M_OFFSET + 1) begin : g_chk_latency
    $error("fios_mm_sequencer: RES_LATENCY (%0d) must be >= %0d",
           RES_LATENCY, (PE_NB - 1) * PE_DELAY + M_OFFSET + 1);
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_t;
  logic [CW-1:0]   w_nextT;
  logic            w_run;
  logic            w_atEnd;
  int              w_tInt;

  assign w_run   = (r_state == RUN);
  assign w_atEnd = (r_t == CW'(T_END));
  assign w_tInt  = int'(r_t);

  // State and run counter. A reset on any cycle, even mid-run, returns to
  // IDLE with the counter cleared, so an abandoned run never produces done.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_nextState;
      r_t     <= w_nextT;
    end
  end

  // Next-state logic. start_i is only looked at in IDLE, so requests arriving
  // during a run are dropped rather than queued. The counter is cleared on
  // leaving RUN, so it never has to wrap.
  always_comb begin
    w_nextState = r_state;
    w_nextT     = '0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_atEnd) begin
          w_nextState = IDLE;
        end else begin
          w_nextT = r_t + CW'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Output decode from registered state and counter only, with no path from
  // start_i. PE k sees the same pattern as PE 0, shifted by k*PE_DELAY.
  // Active windows of neighbouring PEs may overlap when s > PE_DELAY.
  always_comb begin
    ready_o     = !w_run;
    op_valid_o  = 1'b0;
    word_idx_o  = '0;
    a_reg_en_o  = '0;
    m_reg_en_o  = '0;
    pe_active_o = '0;
    res_valid_o = 1'b0;
    res_idx_o   = '0;
    done_o      = 1'b0;
    if (w_run) begin
      if (w_tInt < s) begin
        op_valid_o = 1'b1;
        word_idx_o = r_t[IW-1:0];
      end
      for (int k = 0; k < PE_NB; k++) begin
        a_reg_en_o[k]  = (w_tInt == k * PE_DELAY);
        m_reg_en_o[k]  = (w_tInt == k * PE_DELAY + M_OFFSET);
        pe_active_o[k] = (w_tInt >= k * PE_DELAY) && (w_tInt < k * PE_DELAY + s);
      end
      if (w_tInt >= RES_LATENCY && w_tInt < T_END) begin
        res_valid_o = 1'b1;
        res_idx_o   = IW'(w_tInt - RES_LATENCY);
      end
      done_o = w_atEnd;
    end
  end

endmodule

// File: tb/tb_fios_mm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fios_mm_sequencer
//
// Purpose:
//   Self-checking bench for fios_mm_sequencer. It drives two instances from
//   shared reset/start inputs:
//     - one instance with the default parameters
//     - one instance with s=4, PE_NB=4, RES_LATENCY=35
//   A behavioural model tracks each instance in terms of the cycle at which
//   its run was accepted. Expected outputs come from the elapsed cycle count
//   since that acceptance.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_fios_mm_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;

  logic        rdy8, opv8, rv8, dn8;
  logic [2:0]  widx8, ridx8;
  logic [7:0]  aen8, men8, act8;

  logic        rdy4, opv4, rv4, dn4;
  logic [1:0]  widx4, ridx4;
  logic [3:0]  aen4, men4, act4;

  int          total = 0;
  int          bad   = 0;
  longint      cyc   = 0;

  bit          mRun   [2];
  longint      mStart [2];
  int          pS     [2] = '{8, 4};
  int          pNb    [2] = '{8, 4};
  int          pD     [2] = '{10, 10};
  int          pMo    [2] = '{4, 4};
  int          pRl    [2] = '{90, 35};

  int          aCnt [8];
  int          mCnt [8];
  bit          heldPhase = 1'b0;
  longint      lastA0    = -1;
  int          nSpacing  = 0;

  typedef struct {
    logic       rdy;
    logic       opv;
    logic [7:0] widx;
    logic [7:0] aen;
    logic [7:0] men;
    logic [7:0] act;
    logic       rv;
    logic [7:0] ridx;
    logic       dn;
  } exp_t;

  always #5 clock = ~clock;

  fios_mm_sequencer dut8 (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (start),
    .ready_o     (rdy8),
    .op_valid_o  (opv8),
    .word_idx_o  (widx8),
    .a_reg_en_o  (aen8),
    .m_reg_en_o  (men8),
    .pe_active_o (act8),
    .res_valid_o (rv8),
    .res_idx_o   (ridx8),
    .done_o      (dn8)
  );

  fios_mm_sequencer #(
    .s           (4),
    .PE_NB       (4),
    .PE_DELAY    (10),
    .M_OFFSET    (4),
    .RES_LATENCY (35)
  ) dut4 (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (start),
    .ready_o     (rdy4),
    .op_valid_o  (opv4),
    .word_idx_o  (widx4),
    .a_reg_en_o  (aen4),
    .m_reg_en_o  (men4),
    .pe_active_o (act4),
    .res_valid_o (rv4),
    .res_idx_o   (ridx4),
    .done_o      (dn4)
  );

  // Expected outputs from the elapsed cycles e since a run was accepted. A
  // run lasts until the done cycle at e = RES_LATENCY + s.
  function automatic exp_t modelOut(bit run, int e, int S, int NB, int D, int MO, int RL);
    exp_t x;
    x.rdy  = !run;
    x.opv  = 1'b0;
    x.widx = '0;
    x.aen  = '0;
    x.men  = '0;
    x.act  = '0;
    x.rv   = 1'b0;
    x.ridx = '0;
    x.dn   = 1'b0;
    if (run) begin
      x.opv = (e < S);
      if (x.opv) x.widx = 8'(e);
      for (int k = 0; k < NB; k++) begin
        x.aen[k] = (e == k * D);
        x.men[k] = (e == k * D + MO);
        x.act[k] = (e >= k * D) && (e < k * D + S);
      end
      x.rv = (e >= RL) && (e < RL + S);
      if (x.rv) x.ridx = 8'(e - RL);
      x.dn = (e == RL + S);
    end
    return x;
  endfunction

  task automatic chkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Compare both instances against the model. Also track per-PE enable
  // pulses of the default instance so each one can be counted once per run.
  task automatic checkOutput();
    exp_t x8, x4;
    int   e8, e4;
    e8 = int'(cyc - mStart[0]);
    e4 = int'(cyc - mStart[1]);
    x8 = modelOut(mRun[0], e8, pS[0], pNb[0], pD[0], pMo[0], pRl[0]);
    x4 = modelOut(mRun[1], e4, pS[1], pNb[1], pD[1], pMo[1], pRl[1]);

    chkVal("d8_ready",     32'(rdy8),  32'(x8.rdy));
    chkVal("d8_op_valid",  32'(opv8),  32'(x8.opv));
    chkVal("d8_word_idx",  32'(widx8), 32'(x8.widx));
    chkVal("d8_a_reg_en",  32'(aen8),  32'(x8.aen));
    chkVal("d8_m_reg_en",  32'(men8),  32'(x8.men));
    chkVal("d8_pe_active", 32'(act8),  32'(x8.act));
    chkVal("d8_res_valid", 32'(rv8),   32'(x8.rv));
    chkVal("d8_res_idx",   32'(ridx8), 32'(x8.ridx));
    chkVal("d8_done",      32'(dn8),   32'(x8.dn));

    chkVal("d4_ready",     32'(rdy4),  32'(x4.rdy));
    chkVal("d4_op_valid",  32'(opv4),  32'(x4.opv));
    chkVal("d4_word_idx",  32'(widx4), 32'(x4.widx));
    chkVal("d4_a_reg_en",  32'(aen4),  32'(x4.aen));
    chkVal("d4_m_reg_en",  32'(men4),  32'(x4.men));
    chkVal("d4_pe_active", 32'(act4),  32'(x4.act));
    chkVal("d4_res_valid", 32'(rv4),   32'(x4.rv));
    chkVal("d4_res_idx",   32'(ridx4), 32'(x4.ridx));
    chkVal("d4_done",      32'(dn4),   32'(x4.dn));

    for (int k = 0; k < 8; k++) begin
      if (aen8[k] === 1'b1) aCnt[k]++;
      if (men8[k] === 1'b1) mCnt[k]++;
    end
    if (mRun[0] && e8 == pRl[0] + pS[0]) begin
      for (int k = 0; k < 8; k++) begin
        chkVal($sformatf("d8_a_pulse_count[%0d]", k), 32'(aCnt[k]), 32'd1);
        chkVal($sformatf("d8_m_pulse_count[%0d]", k), 32'(mCnt[k]), 32'd1);
      end
    end

    if (heldPhase && aen8[0] === 1'b1) begin
      if (lastA0 >= 0) begin
        chkVal("d8_held_start_spacing", 32'(cyc - lastA0), 32'd100);
        nSpacing++;
      end
      lastA0 = cyc;
    end
  endtask

  // Drive one cycle of inputs, advance the model across the clock edge, then
  // check outputs 1 time unit after the edge.
  task automatic applyStimulus(bit r, bit st);
    reset = r;
    start = st;
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mRun[i] = 1'b0;
      end else if (mRun[i]) begin
        if (cyc - mStart[i] == longint'(pRl[i] + pS[i])) mRun[i] = 1'b0;
      end else if (st) begin
        mRun[i]   = 1'b1;
        mStart[i] = cyc + 1;
        if (i == 0) begin
          for (int k = 0; k < 8; k++) begin
            aCnt[k] = 0;
            mCnt[k] = 0;
          end
        end
      end
    end
    cyc++;
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mRun[i]   = 1'b0;
      mStart[i] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      aCnt[k] = 0;
      mCnt[k] = 0;
    end

    $display("[TB] reset and idle");
    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0);

    $display("[TB] single start pulse");
    applyStimulus(1'b0, 1'b1);
    repeat (105) applyStimulus(1'b0, 1'b0);

    $display("[TB] start held high");
    heldPhase = 1'b1;
    lastA0    = -1;
    repeat (320) applyStimulus(1'b0, 1'b1);
    heldPhase = 1'b0;
    chkVal("d8_held_spacings_seen", 32'(nSpacing >= 2), 32'd1);
    repeat (100) applyStimulus(1'b0, 1'b0);

    $display("[TB] reset at t=45");
    applyStimulus(1'b0, 1'b1);
    repeat (45) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    repeat (101) applyStimulus(1'b0, 1'b0);

    $display("[TB] randomized start/reset");
    repeat (1500) applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0);
    repeat (5) applyStimulus(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
